// File: rtl/lca_seq_adder.sv
// ============================================================================
// Module   : lca_seq_adder
// Purpose  : Multi-cycle WIDTH-bit adder; one 4-bit carry-lookahead nibble per
//            clock, LSB first. Optional subtract mode via `LCA_SEQ_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef LCA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIB - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("lca_seq_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_s;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_idx == C_LAST_IDX);

`ifdef LCA_SEQ_SUB_EN
  // Subtract as A + ~B + 1; the forced carry replaces c_in.
  assign w_b_load = op_sub ? ~b_in : b_in;
  assign w_c_load = op_sub ? 1'b1 : c_in;
`else
  assign w_b_load = b_in;
  assign w_c_load = c_in;
`endif

  // Current nibble operands
  assign w_a_sh = r_a >> {r_idx, 2'b00};
  assign w_b_sh = r_b >> {r_idx, 2'b00};
  assign w_g    = w_a_sh[3:0] & w_b_sh[3:0];
  assign w_p    = w_a_sh[3:0] ^ w_b_sh[3:0];

  // Fully expanded lookahead carries for one slice
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s    = w_p ^ w_c[3:0];

  generate
    for (genvar i = 0; i < NIB; i++) begin : g_nib
      assign w_sum_next[4*i +: 4] = (r_idx == IDX_W'(i)) ? w_s : r_sum[4*i +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_in;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_c[4];
      if (w_last) begin
        r_co  <= w_c[4];
        r_ovf <= w_c[3] ^ w_c[4];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign sum = r_sum;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_lca_seq_adder.sv
// ============================================================================
// Module   : tb_lca_seq_adder
// Purpose  : Directed self-checking bench for lca_seq_adder (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lca_seq_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lca_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
`ifdef LCA_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one op, scramble inputs during RUN, check latency and result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic sub,
                        input logic [15:0] e_sum, input logic e_co, input logic e_ovf,
                        input bit release_out);
    int k;
    @(negedge clk);
    in_valid = 1'b1; a_in = a; b_in = b; c_in = c; op_sub = sub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a_in = ~a; b_in = ~b; c_in = ~c; op_sub = ~sub;
    k = 0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, NIB);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, e_sum});
    check({tag, "_flags"}, {30'd0, co, ovf}, {30'd0, e_co, e_ovf});
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_rel"}, {30'd0, out_valid, in_ready}, 32'b01);
    end
  endtask

  logic [15:0] ops_a [3] = '{16'h0100, 16'hA5A5, 16'h4000};
  logic [15:0] ops_b [3] = '{16'h00FF, 16'h5A5A, 16'h4000};
  logic        ops_c [3] = '{1'b0, 1'b1, 1'b0};
  logic [17:0] ops_e [3] = '{{2'b00, 16'h01FF}, {2'b10, 16'h0000}, {2'b01, 16'h8000}};

  initial begin
    int acc_n;
    int res_n;
    int cyc;
    int last_acc;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    op_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hs", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst_out", {14'd0, co, ovf, sum}, 32'd0);
    rst = 1'b0;

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("ripl", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);

    // Backpressure
    run_op("bp", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {12'd0, out_valid, in_ready, co, ovf, sum}, {12'd0, 4'b1011, 16'h0000});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset at RUN idx=2
    @(negedge clk);
    in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst", {13'd0, out_valid, in_ready, busy, sum}, {13'd0, 3'b010, 16'h0000});
    run_op("post", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    // Back-to-back with in_valid held and out_ready high
    acc_n = 0; res_n = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    while (res_n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check("b2b_res", {14'd0, co, ovf, sum}, {14'd0, ops_e[res_n]});
        res_n++;
      end
      if (in_ready) begin
        if (acc_n < 3) begin
          if (last_acc >= 0) check("b2b_gap", cyc - last_acc, 6);
          last_acc = cyc;
          in_valid = 1'b1;
          a_in = ops_a[acc_n]; b_in = ops_b[acc_n]; c_in = ops_c[acc_n];
          acc_n++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        a_in = ~a_in;
      end
    end
    check("b2b_cnt", res_n, 3);
    in_valid = 1'b0; out_ready = 1'b0;

`ifdef LCA_SEQ_SUB_EN
    run_op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    run_op("sub2", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
